// File: rtl/dsp_pkg.sv
// dsp_pkg: OPMODE constants, pipeline tags and FSM state encoding shared by the MAC sequencer
package dsp_pkg;

    localparam logic [7:0] OPM_ZERO     = 8'b0000_0000;
    localparam logic [7:0] OPM_M        = 8'b0000_0001;
    localparam logic [7:0] OPM_C_PLUS_M = 8'b0000_1101;
    localparam logic [7:0] OPM_P_PLUS_M = 8'b0000_1001;
    localparam logic [7:0] OPM_HOLD     = 8'b0000_1000;

    typedef enum logic [1:0] {
        TAG_NONE   = 2'd0,
        TAG_FIRST  = 2'd1,
        TAG_ACC    = 2'd2,
        TAG_BUBBLE = 2'd3
    } tag_e;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_RESP  = 2'd3;

endpackage

// File: rtl/dsp_mac_sequencer_if.sv
// dsp_mac_sequencer_if: job command, operand stream and result channels of the MAC sequencer
interface dsp_mac_sequencer_if #(
    parameter int DATA_W = 18,
    parameter int ACC_W  = 48,
    parameter int CNT_W  = 10
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [CNT_W-1:0]         cmd_len;
    logic                     cmd_bias_en;
    logic signed [ACC_W-1:0]  cmd_bias;
    logic                     op_valid;
    logic                     op_ready;
    logic signed [DATA_W-1:0] op_a;
    logic signed [DATA_W-1:0] op_b;
    logic                     res_valid;
    logic                     res_ready;
    logic signed [ACC_W-1:0]  res_data;

    modport master (
        output cmd_valid, cmd_len, cmd_bias_en, cmd_bias, op_valid, op_a, op_b, res_ready,
        input  cmd_ready, op_ready, res_valid, res_data
    );

    modport slave (
        input  cmd_valid, cmd_len, cmd_bias_en, cmd_bias, op_valid, op_a, op_b, res_ready,
        output cmd_ready, op_ready, res_valid, res_data
    );

endinterface

// File: rtl/dsp_tag_pipe.sv
// dsp_tag_pipe: delays the tag of each presented operand pair until its product reaches the post-adder
module dsp_tag_pipe
    import dsp_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clr_i,
    input  tag_e tag_i,
    output tag_e tag_o
);

    tag_e pipe_q [DEPTH];

    // shift one tag per cycle; a clear flushes tags left over from the previous job
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) pipe_q[i] <= TAG_NONE;
        end else begin
            pipe_q[0] <= clr_i ? TAG_NONE : tag_i;
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= clr_i ? TAG_NONE : pipe_q[i-1];
        end
    end

    assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: feeds operand pairs into a DSP slice with aligned OPMODE and returns the accumulated P
module dsp_mac_sequencer
    import dsp_pkg::*;
#(
    parameter int DATA_W = 18,
    parameter int ACC_W  = 48,
    parameter int CNT_W  = 10,
    parameter int LAT_M  = 3
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    dsp_mac_sequencer_if.slave       host,
    output logic                     busy,
    output logic signed [DATA_W-1:0] dsp_a,
    output logic signed [DATA_W-1:0] dsp_b,
    output logic signed [DATA_W-1:0] dsp_d,
    output logic signed [ACC_W-1:0]  dsp_c,
    output logic [7:0]               dsp_opmode,
    output logic                     dsp_carryin,
    input  logic signed [ACC_W-1:0]  dsp_p
);

    localparam int DCNT_W = $clog2(LAT_M + 2);

    state_t                   state_q, state_d;
    logic                     cmd_rdy_q, cmd_rdy_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [DCNT_W-1:0]        dcnt_q, dcnt_d;
    logic                     bias_en_q, bias_en_d;
    logic                     first_q, first_d;
    logic signed [ACC_W-1:0]  c_q, c_d;
    logic signed [ACC_W-1:0]  res_q, res_d;
    logic signed [DATA_W-1:0] a_q, a_d;
    logic signed [DATA_W-1:0] b_q, b_d;
    tag_e                     tag_q, tag_d, tag_out;
    logic                     cmd_hs, op_hs;

    assign cmd_hs = host.cmd_valid && cmd_rdy_q;
    assign op_hs  = host.op_valid && (state_q == ST_RUN);

    // job sequencing: latch the command, stream pairs with their tags, wait out the slice latency, hold the result
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dcnt_d    = dcnt_q;
        bias_en_d = bias_en_q;
        first_d   = first_q;
        c_d       = c_q;
        res_d     = res_q;
        a_d       = '0;
        b_d       = '0;
        tag_d     = TAG_NONE;
        case (state_q)
            ST_IDLE: if (cmd_hs) begin
                bias_en_d = host.cmd_bias_en;
                c_d       = host.cmd_bias_en ? host.cmd_bias : '0;
                res_d     = host.cmd_bias_en ? host.cmd_bias : '0;
                cnt_d     = host.cmd_len;
                first_d   = 1'b0;
                state_d   = (host.cmd_len == '0) ? ST_RESP : ST_RUN;
            end
            ST_RUN: begin
                tag_d = op_hs ? (first_q ? TAG_ACC : TAG_FIRST) : (first_q ? TAG_BUBBLE : TAG_NONE);
                if (op_hs) begin
                    a_d     = host.op_a;
                    b_d     = host.op_b;
                    first_d = 1'b1;
                    cnt_d   = cnt_q - CNT_W'(1);
                    dcnt_d  = '0;
                    state_d = (cnt_q == CNT_W'(1)) ? ST_DRAIN : ST_RUN;
                end
            end
            ST_DRAIN: begin
                tag_d  = TAG_BUBBLE;
                dcnt_d = dcnt_q + DCNT_W'(1);
                if (dcnt_q == DCNT_W'(LAT_M + 1)) begin
                    res_d   = dsp_p;
                    state_d = ST_RESP;
                end
            end
            default: if (host.res_ready) state_d = ST_IDLE;
        endcase
    end

    assign cmd_rdy_d = (state_d == ST_IDLE);

    // state and slice-facing registers; cmd_ready is registered so it stays low while reset is held
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            cmd_rdy_q <= 1'b0;
            cnt_q     <= '0;
            dcnt_q    <= '0;
            bias_en_q <= 1'b0;
            first_q   <= 1'b0;
            c_q       <= '0;
            res_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            tag_q     <= TAG_NONE;
        end else begin
            state_q   <= state_d;
            cmd_rdy_q <= cmd_rdy_d;
            cnt_q     <= cnt_d;
            dcnt_q    <= dcnt_d;
            bias_en_q <= bias_en_d;
            first_q   <= first_d;
            c_q       <= c_d;
            res_q     <= res_d;
            a_q       <= a_d;
            b_q       <= b_d;
            tag_q     <= tag_d;
        end
    end

    dsp_tag_pipe #(.DEPTH(LAT_M)) u_tag_pipe (
        .CLK   (CLK),
        .RST_N (RST_N),
        .clr_i (cmd_hs),
        .tag_i (tag_q),
        .tag_o (tag_out)
    );

    assign dsp_opmode = (state_q == ST_IDLE)   ? OPM_ZERO :
                        (tag_out == TAG_FIRST)  ? (bias_en_q ? OPM_C_PLUS_M : OPM_M) :
                        (tag_out == TAG_ACC)    ? OPM_P_PLUS_M :
                        (tag_out == TAG_BUBBLE) ? OPM_HOLD : OPM_ZERO;

    assign dsp_a          = a_q;
    assign dsp_b          = b_q;
    assign dsp_c          = c_q;
    assign dsp_d          = '0;
    assign dsp_carryin    = 1'b0;
    assign busy           = (state_q != ST_IDLE);
    assign host.cmd_ready = cmd_rdy_q;
    assign host.op_ready  = (state_q == ST_RUN);
    assign host.res_valid = (state_q == ST_RESP);
    assign host.res_data  = res_q;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb_dsp_mac_sequencer: sequencer driving a behavioural DSP slice, results checked through a scoreboard
module tb_dsp_mac_sequencer;

    localparam int DATA_W = 18;
    localparam int ACC_W  = 48;
    localparam int CNT_W  = 10;
    localparam int LAT_M  = 3;

    typedef struct {
        logic signed [ACC_W-1:0] data;
        int                      lat;
    } exp_t;

    logic CLK = 1'b0;
    logic RST_N = 1'b1;
    always #5 CLK = ~CLK;

    dsp_mac_sequencer_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) host ();

    logic                     busy;
    logic signed [DATA_W-1:0] dsp_a, dsp_b, dsp_d;
    logic signed [ACC_W-1:0]  dsp_c, dsp_p;
    logic [7:0]               dsp_opmode;
    logic                     dsp_carryin;

    dsp_mac_sequencer #(.DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .LAT_M(LAT_M)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .host        (host),
        .busy        (busy),
        .dsp_a       (dsp_a),
        .dsp_b       (dsp_b),
        .dsp_d       (dsp_d),
        .dsp_c       (dsp_c),
        .dsp_opmode  (dsp_opmode),
        .dsp_carryin (dsp_carryin),
        .dsp_p       (dsp_p)
    );

    // behavioural slice: A0/A1 and B0/B1 registers, MREG, registered P with X/Z muxes from OPMODE
    logic signed [DATA_W-1:0]   a0 = '0, a1 = '0, b0 = '0, b1 = '0;
    logic signed [2*DATA_W-1:0] m_r = '0;
    logic signed [ACC_W-1:0]    p_r = '0;
    logic signed [ACC_W-1:0]    x_v, z_v;

    always_comb begin
        x_v = (dsp_opmode[1:0] == 2'b01) ? ACC_W'(m_r) : '0;
        z_v = (dsp_opmode[3:2] == 2'b10) ? p_r : (dsp_opmode[3:2] == 2'b11) ? dsp_c : '0;
    end

    always @(posedge CLK) begin
        a0  <= dsp_a;
        a1  <= a0;
        b0  <= dsp_b;
        b1  <= b0;
        m_r <= a1 * b1;
        p_r <= z_v + x_v;
    end

    assign dsp_p = p_r;

    int   errors = 0, checks = 0;
    int   cyc = 0, cmd_cyc = 0, rv_cyc = 0;
    bit   rv_seen = 1'b0;
    exp_t sb[$];
    exp_t mon_e;
    logic [7:0] opm_hist [256];
    logic signed [DATA_W-1:0] pa [8], pb [8];

    always @(posedge CLK) cyc <= cyc + 1;

    // scoreboard monitor: pops on every result handshake, checks value and latency plus ready exclusivity
    always @(negedge CLK) begin
        if (!RST_N) begin
            rv_seen = 1'b0;
        end else begin
            opm_hist[cyc % 256] = dsp_opmode;
            checks++;
            if (host.cmd_ready && (host.op_ready || host.res_valid)) begin
                errors++;
                $display("FAIL ready_exclusive cyc=%0d: cmd_ready=%0b op_ready=%0b res_valid=%0b, required cmd_ready low with either", cyc, host.cmd_ready, host.op_ready, host.res_valid);
            end
            if (host.cmd_valid && host.cmd_ready) cmd_cyc = cyc;
            if (host.res_valid && !rv_seen) begin
                rv_seen = 1'b1;
                rv_cyc  = cyc;
            end
            if (host.res_valid && host.res_ready) begin
                rv_seen = 1'b0;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got res_data=%0d, required no result", host.res_data);
                end else begin
                    mon_e = sb.pop_front();
                    if (host.res_data !== mon_e.data) begin
                        errors++;
                        $display("FAIL res_data: got %0d, required %0d", host.res_data, mon_e.data);
                    end
                    checks++;
                    if (rv_cyc - cmd_cyc - 1 !== mon_e.lat) begin
                        errors++;
                        $display("FAIL res_latency: got %0d, required %0d", rv_cyc - cmd_cyc - 1, mon_e.lat);
                    end
                end
            end
        end
    end

    task automatic run_job(input int n, input bit ben, input logic signed [ACC_W-1:0] bias, input int gap_at, input int gap_n);
        logic signed [ACC_W-1:0] acc;
        exp_t e;
        int   t;
        acc = ben ? bias : '0;
        for (int i = 0; i < n; i++) acc += ACC_W'(longint'(pa[i]) * longint'(pb[i]));
        e.data = acc;
        e.lat  = (n == 0) ? 0 : n + LAT_M + 2 + gap_n;
        sb.push_back(e);
        host.cmd_len     = CNT_W'(n);
        host.cmd_bias_en = ben;
        host.cmd_bias    = bias;
        host.cmd_valid   = 1'b1;
        t = 0;
        while (!host.cmd_ready && t < 50) begin
            @(posedge CLK);
            #1;
            t++;
        end
        if (t == 50) begin
            checks++;
            errors++;
            $display("FAIL cmd_timeout: got cmd_ready=0 for 50 cycles, required 1");
        end
        @(posedge CLK);
        #1;
        host.cmd_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) repeat (gap_n) begin
                @(posedge CLK);
                #1;
            end
            host.op_a     = pa[i];
            host.op_b     = pb[i];
            host.op_valid = 1'b1;
            t = 0;
            while (!host.op_ready && t < 50) begin
                @(posedge CLK);
                #1;
                t++;
            end
            if (t == 50) begin
                checks++;
                errors++;
                $display("FAIL op_timeout: got op_ready=0 for 50 cycles, required 1");
            end
            @(posedge CLK);
            #1;
            host.op_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge CLK);
            #1;
            t++;
        end
        if (t == 200) begin
            checks++;
            errors++;
            $display("FAIL result_timeout: got %0d results pending, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        #1 RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({host.cmd_ready, host.op_ready, host.res_valid, busy, dsp_carryin} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, required 00000", {host.cmd_ready, host.op_ready, host.res_valid, busy, dsp_carryin});
        end
        checks++;
        if (dsp_opmode !== 8'h00) begin
            errors++;
            $display("FAIL reset_opmode: got %b, required 00000000", dsp_opmode);
        end
        checks++;
        if ({dsp_a, dsp_b, dsp_d, dsp_c, host.res_data} !== '0) begin
            errors++;
            $display("FAIL reset_data: got a=%0d b=%0d d=%0d c=%0d res=%0d, required all 0", dsp_a, dsp_b, dsp_d, dsp_c, host.res_data);
        end
        @(posedge CLK);
        #3 RST_N = 1'b1;
        @(posedge CLK);
        #1;
        checks++;
        if ({host.cmd_ready, busy} !== 2'b10) begin
            errors++;
            $display("FAIL post_reset_idle: got cmd_ready=%0b busy=%0b, required 1 0", host.cmd_ready, busy);
        end
    endtask

    task automatic test_single();
        pa[0] = 18'sd3;
        pb[0] = -18'sd5;
        run_job(1, 1'b0, '0, -1, 0);
        wait_drain();
    endtask

    task automatic test_mac_bias();
        pa[0] = 18'sd1;  pb[0] = 18'sd2;
        pa[1] = 18'sd3;  pb[1] = 18'sd4;
        pa[2] = -18'sd5; pb[2] = 18'sd6;
        pa[3] = 18'sd7;  pb[3] = -18'sd8;
        run_job(4, 1'b1, 48'sd100, -1, 0);
        wait_drain();
    endtask

    task automatic test_bubbles();
        logic [7:0] win [8];
        win = '{8'h00, 8'h0D, 8'h09, 8'h08, 8'h08, 8'h09, 8'h09, 8'h08};
        run_job(4, 1'b1, 48'sd100, 2, 2);
        wait_drain();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (opm_hist[(cmd_cyc + 4 + k) % 256] !== win[k]) begin
                errors++;
                $display("FAIL bubble_opmode[+%0d]: got %b, required %b", 4 + k, opm_hist[(cmd_cyc + 4 + k) % 256], win[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        int t = 0;
        host.res_ready = 1'b0;
        pa[0] = 18'sd10; pb[0] = 18'sd20;
        pa[1] = -18'sd3; pb[1] = 18'sd3;
        run_job(2, 1'b0, '0, -1, 0);
        while (!host.res_valid && t < 100) begin
            @(posedge CLK);
            #1;
            t++;
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({host.res_valid, host.cmd_ready} !== 2'b10 || host.res_data !== 48'sd191) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: got res_valid=%0b cmd_ready=%0b res_data=%0d, required 1 0 191", k, host.res_valid, host.cmd_ready, host.res_data);
            end
            @(posedge CLK);
            #1;
        end
        host.res_ready = 1'b1;
        wait_drain();
        run_job(0, 1'b1, -48'sd7, -1, 0);
        wait_drain();
    endtask

    task automatic test_extremes();
        for (int i = 0; i < 3; i++) begin
            pa[i] = 18'sh20000;
            pb[i] = 18'sh20000;
        end
        run_job(3, 1'b0, '0, -1, 0);
        wait_drain();
    endtask

    task automatic test_reset_midjob();
        host.cmd_len     = CNT_W'(5);
        host.cmd_bias_en = 1'b1;
        host.cmd_bias    = 48'sd1000;
        host.cmd_valid   = 1'b1;
        @(posedge CLK);
        #1;
        host.cmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            host.op_a     = DATA_W'(9 + i);
            host.op_b     = DATA_W'(11);
            host.op_valid = 1'b1;
            @(posedge CLK);
            #1;
        end
        checks++;
        if ({host.op_ready, busy} !== 2'b11) begin
            errors++;
            $display("FAIL midjob_running: got op_ready=%0b busy=%0b, required 1 1", host.op_ready, busy);
        end
        #2 RST_N = 1'b0;
        #1;
        host.op_valid = 1'b0;
        sb.delete();
        checks++;
        if ({host.cmd_ready, host.op_ready, host.res_valid, busy, dsp_opmode} !== '0) begin
            errors++;
            $display("FAIL midjob_reset_ctrl: got cmd=%0b op=%0b res=%0b busy=%0b opm=%b, required all 0", host.cmd_ready, host.op_ready, host.res_valid, busy, dsp_opmode);
        end
        checks++;
        if ({dsp_a, dsp_b, dsp_c, host.res_data} !== '0) begin
            errors++;
            $display("FAIL midjob_reset_data: got a=%0d b=%0d c=%0d res=%0d, required all 0", dsp_a, dsp_b, dsp_c, host.res_data);
        end
        repeat (2) @(posedge CLK);
        #3 RST_N = 1'b1;
        @(posedge CLK);
        #1;
        pa[0] = 18'sd2;
        pb[0] = 18'sd2;
        run_job(1, 1'b0, '0, -1, 0);
        wait_drain();
    endtask

    initial begin
        host.cmd_valid   = 1'b0;
        host.cmd_len     = '0;
        host.cmd_bias_en = 1'b0;
        host.cmd_bias    = '0;
        host.op_valid    = 1'b0;
        host.op_a        = '0;
        host.op_b        = '0;
        host.res_ready   = 1'b1;
        test_reset();
        test_single();
        test_mac_bias();
        test_bubbles();
        test_backpressure();
        test_extremes();
        test_reset_midjob();
        repeat (3) @(posedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
